mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin CPU/loader arbiter and fixed-latency access sequencer for a shared memory
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [WIDTH-1:0] c_addr,
  input  logic [WIDTH-1:0] c_wdata,
  output logic             c_done,
  input  logic             l_req,
  input  logic             l_we,
  input  logic [WIDTH-1:0] l_addr,
  input  logic [WIDTH-1:0] l_wdata,
  output logic             l_done,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             m_en,
  output logic             m_we,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic own_q, own_d, we_q, we_d, last_q, last_d, l_win;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    we_d    = we_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    // own/last encode 1 = loader; on a tie the port not granted last wins
    l_win   = l_req & (~c_req | ~last_q);
    case (state_q)
      IDLE: if (c_req | l_req) begin
        own_d   = l_win;
        we_d    = l_win ? l_we : c_we;
        addr_d  = l_win ? l_addr : c_addr;
        wdata_d = l_win ? l_wdata : c_wdata;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = 4'(LAT - 1);
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: if (cnt_q == 4'd0) begin
        rdata_d = m_rdata;
        state_d = RESP;
      end else cnt_d = cnt_q - 4'd1;
      RESP: begin
        last_d  = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      we_q    <= we_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy    = state_q != IDLE;
  assign m_en    = state_q == ISSUE;
  assign m_we    = m_en & we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign c_done  = (state_q == RESP) & ~own_q;
  assign l_done  = (state_q == RESP) & own_q;
  assign rdata   = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, reset and request-drop behaviour
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic c_req = 0, c_we = 0, l_req = 0, l_we = 0;
  logic [31:0] c_addr = 0, c_wdata = 0, l_addr = 0, l_wdata = 0;
  logic c_done, l_done, busy, m_en, m_we;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;
  logic x1_req = 0, x15_req = 0;
  logic x1_cd, x1_ld, x1_busy, x1_en, x1_we, x15_cd, x15_ld, x15_busy, x15_en, x15_we;
  logic [31:0] x1_rd, x1_ma, x1_mw, x15_rd, x15_ma, x15_mw;
  logic [31:0] mem [16];
  logic [31:0] p0, p1;
  int errors = 0, checks = 0, men_n = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(32), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_done(c_done),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_done(l_done),
    .rdata(rdata), .busy(busy), .m_en(m_en), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata));

  mem_port_arbiter #(.WIDTH(32), .LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .c_req(x1_req), .c_we(1'b0), .c_addr(32'h0), .c_wdata(32'h0), .c_done(x1_cd),
    .l_req(1'b0), .l_we(1'b0), .l_addr(32'h0), .l_wdata(32'h0), .l_done(x1_ld),
    .rdata(x1_rd), .busy(x1_busy), .m_en(x1_en), .m_we(x1_we),
    .m_addr(x1_ma), .m_wdata(x1_mw), .m_rdata(32'h0));

  mem_port_arbiter #(.WIDTH(32), .LAT(15)) dut15 (
    .clk(clk), .rst(rst),
    .c_req(x15_req), .c_we(1'b0), .c_addr(32'h0), .c_wdata(32'h0), .c_done(x15_cd),
    .l_req(1'b0), .l_we(1'b0), .l_addr(32'h0), .l_wdata(32'h0), .l_done(x15_ld),
    .rdata(x15_rd), .busy(x15_busy), .m_en(x15_en), .m_we(x15_we),
    .m_addr(x15_ma), .m_wdata(x15_mw), .m_rdata(32'h0));

  // two-stage read pipe models the LAT=2 synchronous memory
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr[5:2]] <= m_wdata;
    p0 <= (m_en && !m_we) ? mem[m_addr[5:2]] : 32'h0BAD0BAD;
    p1 <= p0;
    if (m_en) men_n <= men_n + 1;
  end
  assign m_rdata = p1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    tick(); tick();
    chk("rst_busy", busy, 0); chk("rst_men", m_en, 0); chk("rst_mwe", m_we, 0);
    chk("rst_maddr", m_addr, 0); chk("rst_mwdata", m_wdata, 0); chk("rst_rdata", rdata, 0);
    chk("rst_cdone", c_done, 0); chk("rst_ldone", l_done, 0);
    rst = 0;
    tick();
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
    chk("w_c0_busy", busy, 0);
    tick();
    chk("w_c1_men", m_en, 1); chk("w_c1_mwe", m_we, 1); chk("w_c1_addr", m_addr, 32'h10);
    chk("w_c1_wdata", m_wdata, 32'hDEADBEEF); chk("w_c1_busy", busy, 1); chk("w_c1_cdone", c_done, 0);
    tick();
    chk("w_c2_cdone", c_done, 1); chk("w_c2_ldone", l_done, 0); chk("w_c2_men", m_en, 0);
    c_req = 0; c_we = 0;
    tick();
    chk("w_c3_cdone", c_done, 0); chk("w_c3_busy", busy, 0);
    n0 = men_n;
    l_req = 1; l_we = 0; l_addr = 32'h10;
    tick();
    chk("lr_c1_men", m_en, 1); chk("lr_c1_mwe", m_we, 0);
    tick();
    chk("lr_c2_men", m_en, 0); chk("lr_c2_ldone", l_done, 0);
    tick();
    chk("lr_c3_ldone", l_done, 0);
    tick();
    chk("lr_c4_ldone", l_done, 1); chk("lr_c4_cdone", c_done, 0); chk("lr_c4_rdata", rdata, 32'hDEADBEEF);
    l_req = 0;
    tick();
    chk("lr_c5_busy", busy, 0); chk("lr_men_pulses", 32'(men_n - n0), 1);
    l_req = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'h12345678;
    tick(); tick();
    chk("lw_c2_ldone", l_done, 1);
    l_req = 0; l_we = 0;
    tick();
    c_req = 1; l_req = 1; c_addr = 32'h10; l_addr = 32'h20;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("rr_c%0d_cdone", k), c_done, (k == 4 || k == 14));
      chk($sformatf("rr_c%0d_ldone", k), l_done, (k == 9 || k == 19));
      chk($sformatf("rr_c%0d_men", k), m_en, (k == 1 || k == 6 || k == 11 || k == 16));
      if (k == 4 || k == 14) chk($sformatf("rr_c%0d_rdata", k), rdata, 32'hDEADBEEF);
      if (k == 9 || k == 19) chk($sformatf("rr_c%0d_rdata", k), rdata, 32'h12345678);
      if (k == 19) begin c_req = 0; l_req = 0; end
      tick();
    end
    chk("rr_end_busy", busy, 0);
    x1_req = 1; x15_req = 1;
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("lat1_c%0d_done", k), x1_cd, (k == 3));
      chk($sformatf("lat15_c%0d_done", k), x15_cd, (k == 17));
      if (k == 3) x1_req = 0;
      if (k == 17) x15_req = 0;
      tick();
    end
    chk("lat15_end_busy", x15_busy, 0);
    c_req = 1; c_addr = 32'h20;
    tick(); tick(); tick();
    rst = 1;
    #1;
    chk("mr_busy", busy, 0); chk("mr_men", m_en, 0); chk("mr_mwe", m_we, 0);
    chk("mr_maddr", m_addr, 0); chk("mr_rdata", rdata, 0); chk("mr_cdone", c_done, 0);
    c_req = 0;
    tick();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mr_post%0d_cdone", k), c_done, 0);
      chk($sformatf("mr_post%0d_busy", k), busy, 0);
    end
    c_req = 1; c_addr = 32'h10;
    tick(); tick(); tick();
    chk("fr_c3_cdone", c_done, 0);
    tick();
    chk("fr_c4_cdone", c_done, 1); chk("fr_c4_rdata", rdata, 32'hDEADBEEF);
    c_req = 0;
    tick();
    chk("fr_c5_busy", busy, 0);
    c_req = 1; c_addr = 32'h20;
    tick(); tick();
    c_req = 0;
    tick();
    chk("drop_c3_cdone", c_done, 0); chk("drop_c3_busy", busy, 1);
    tick();
    chk("drop_c4_cdone", c_done, 1); chk("drop_c4_rdata", rdata, 32'h12345678);
    tick();
    chk("drop_c5_busy", busy, 0); chk("drop_c5_cdone", c_done, 0);
    tick();
    chk("drop_c6_busy", busy, 0); chk("drop_c6_men", m_en, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
